// File: rtl/voice_allocator_if.sv
// Note-allocation bus between song_reader/player control and the voice bank.
// The master drives note requests and done pulses; the slave (allocator) returns loads and status.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 3
);
    logic                  flush;
    logic                  play;
    logic                  new_note;
    logic [5:0]            note;
    logic [5:0]            duration;
    logic [NUM_VOICES-1:0] voice_done;
    logic [NUM_VOICES-1:0] voice_load;
    logic [5:0]            voice_note;
    logic [5:0]            voice_duration;
    logic [NUM_VOICES-1:0] voice_busy;
    logic                  all_idle;
    logic                  note_dropped;
    logic                  note_stolen;

    modport master (
        output flush, play, new_note, note, duration, voice_done,
        input  voice_load, voice_note, voice_duration, voice_busy,
               all_idle, note_dropped, note_stolen
    );

    modport slave (
        input  flush, play, new_note, note, duration, voice_done,
        output voice_load, voice_note, voice_duration, voice_busy,
               all_idle, note_dropped, note_stolen
    );
endinterface

// File: rtl/voice_allocator.sv
// Routes each new note to the lowest free voice, or steals the oldest / drops it when all are busy.
// Voice age is tracked as a per-voice rank where 0 is the most recently loaded voice.
module voice_allocator #(
    parameter int NUM_VOICES = 3,
    parameter bit STEAL      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    voice_allocator_if.slave   bus
);
    localparam logic [1:0] OLDEST = 2'(NUM_VOICES - 1);

    logic [NUM_VOICES-1:0] busy_q, busy_d;
    logic [NUM_VOICES-1:0] eff_busy;
    logic [NUM_VOICES-1:0] pick;
    logic [NUM_VOICES-1:0] load_d, load_q;
    logic [1:0]            rank_q [NUM_VOICES];
    logic [1:0]            rank_d [NUM_VOICES];
    logic [1:0]            old_rank;
    logic                  accept, free_found, victim_found;
    logic                  stolen_d, stolen_q, dropped_d, dropped_q;
    logic                  all_idle_q;
    logic [5:0]            note_q, duration_q;

    always_comb begin
        eff_busy     = busy_q & ~bus.voice_done;
        accept       = bus.new_note & bus.play & ~bus.flush & (bus.note != 6'd0);
        pick         = '0;
        free_found   = 1'b0;
        victim_found = 1'b0;
        old_rank     = OLDEST;
        load_d       = '0;
        stolen_d     = 1'b0;
        dropped_d    = 1'b0;
        busy_d       = eff_busy;
        for (int i = 0; i < NUM_VOICES; i++) begin
            rank_d[i] = bus.voice_done[i] ? OLDEST : rank_q[i];
        end

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!free_found && !eff_busy[i]) begin
                pick[i]    = 1'b1;
                free_found = 1'b1;
            end
        end
        // No free voice: victim is the oldest; fall back to voice 0 if ranks ever collide after done.
        if (!free_found) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (!victim_found && rank_q[i] == OLDEST) begin
                    pick[i]      = 1'b1;
                    victim_found = 1'b1;
                end
            end
            if (!victim_found) begin
                pick[0]  = 1'b1;
                old_rank = rank_q[0];
            end
        end

        if (accept && (free_found || STEAL)) begin
            load_d   = pick;
            stolen_d = ~free_found;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (pick[i]) begin
                    rank_d[i] = 2'd0;
                    busy_d[i] = 1'b1;
                end else if (eff_busy[i] && rank_q[i] < old_rank) begin
                    rank_d[i] = rank_q[i] + 2'd1;
                end
            end
        end else if (accept) begin
            dropped_d = 1'b1;
        end

        if (bus.flush) begin
            busy_d    = '0;
            load_d    = '0;
            stolen_d  = 1'b0;
            dropped_d = 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_d[i] = OLDEST;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q     <= '0;
            load_q     <= '0;
            stolen_q   <= 1'b0;
            dropped_q  <= 1'b0;
            all_idle_q <= 1'b1;
            note_q     <= '0;
            duration_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i] <= OLDEST;
            end
        end else begin
            busy_q     <= busy_d;
            load_q     <= load_d;
            stolen_q   <= stolen_d;
            dropped_q  <= dropped_d;
            all_idle_q <= ~|busy_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank_q[i] <= rank_d[i];
            end
            if (|load_d) begin
                note_q     <= bus.note;
                duration_q <= bus.duration;
            end
        end
    end

    assign bus.voice_load     = load_q;
    assign bus.voice_note     = note_q;
    assign bus.voice_duration = duration_q;
    assign bus.voice_busy     = busy_q;
    assign bus.all_idle       = all_idle_q;
    assign bus.note_dropped   = dropped_q;
    assign bus.note_stolen    = stolen_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: a stealing and a dropping instance see identical stimulus,
// expected outputs are queued when a step is driven and compared one cycle later.
module tb_voice_allocator;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_VOICES(3)) ifa ();
    voice_allocator_if #(.NUM_VOICES(3)) ifb ();

    voice_allocator #(.NUM_VOICES(3), .STEAL(1'b1)) u_steal (.clk(clk), .reset(reset), .bus(ifa));
    voice_allocator #(.NUM_VOICES(3), .STEAL(1'b0)) u_drop  (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct packed {
        logic [2:0] load;
        logic [5:0] vnote;
        logic [5:0] vdur;
        logic [2:0] busy;
        logic       idle;
        logic       dropped;
        logic       stolen;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   step_no = 0;

    function automatic exp_t mk(input logic [2:0] load, input logic [5:0] vnote, input logic [5:0] vdur,
                                input logic [2:0] busy, input logic idle, input logic dropped,
                                input logic stolen);
        exp_t e;
        e.load = load; e.vnote = vnote; e.vdur = vdur; e.busy = busy;
        e.idle = idle; e.dropped = dropped; e.stolen = stolen;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_dut(input string who, input exp_t e,
                             input logic [2:0] load, input logic [5:0] vnote, input logic [5:0] vdur,
                             input logic [2:0] busy, input logic idle, input logic dropped,
                             input logic stolen);
        string p;
        p = $sformatf("%s step%0d", who, step_no);
        chk({p, " voice_load"},     8'(load),    8'(e.load));
        chk({p, " voice_note"},     8'(vnote),   8'(e.vnote));
        chk({p, " voice_duration"}, 8'(vdur),    8'(e.vdur));
        chk({p, " voice_busy"},     8'(busy),    8'(e.busy));
        chk({p, " all_idle"},       8'(idle),    8'(e.idle));
        chk({p, " note_dropped"},   8'(dropped), 8'(e.dropped));
        chk({p, " note_stolen"},    8'(stolen),  8'(e.stolen));
    endtask

    task automatic check_a(input exp_t e);
        check_dut("steal", e, ifa.voice_load, ifa.voice_note, ifa.voice_duration, ifa.voice_busy,
                  ifa.all_idle, ifa.note_dropped, ifa.note_stolen);
    endtask

    task automatic check_b(input exp_t e);
        check_dut("drop", e, ifb.voice_load, ifb.voice_note, ifb.voice_duration, ifb.voice_busy,
                  ifb.all_idle, ifb.note_dropped, ifb.note_stolen);
    endtask

    task automatic sb_check();
        if (q_a.size() > 0) check_a(q_a.pop_front());
        if (q_b.size() > 0) check_b(q_b.pop_front());
    endtask

    task automatic drive(input logic nn, input logic [5:0] n, input logic [5:0] d,
                         input logic [2:0] done, input logic pl, input logic fl);
        ifa.new_note = nn; ifa.note = n; ifa.duration = d; ifa.voice_done = done; ifa.play = pl; ifa.flush = fl;
        ifb.new_note = nn; ifb.note = n; ifb.duration = d; ifb.voice_done = done; ifb.play = pl; ifb.flush = fl;
    endtask

    // Check what the previous step produced, then drive this step and queue its expected outcome.
    task automatic step(input logic nn, input logic [5:0] n, input logic [5:0] d,
                        input logic [2:0] done, input logic pl, input logic fl,
                        input exp_t ea, input exp_t eb);
        @(negedge clk);
        sb_check();
        step_no++;
        drive(nn, n, d, done, pl, fl);
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        drive(1'b0, 6'd0, 6'd0, 3'b000, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        e = mk(3'b000, 6'd0, 6'd0, 3'b000, 1'b1, 1'b0, 1'b0);
        check_a(e);
        check_b(e);
        reset = 1'b0;

        // Fill all three voices back to back.
        e = mk(3'b001, 6'd10, 6'd4, 3'b001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd10, 6'd4, 3'b000, 1'b1, 1'b0, e, e);
        e = mk(3'b010, 6'd20, 6'd8, 3'b011, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd20, 6'd8, 3'b000, 1'b1, 1'b0, e, e);
        e = mk(3'b100, 6'd30, 6'd12, 3'b111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd30, 6'd12, 3'b000, 1'b1, 1'b0, e, e);

        // All busy: steal oldest (voice 0) vs drop.
        step(1'b1, 6'd40, 6'd16, 3'b000, 1'b1, 1'b0,
             mk(3'b001, 6'd40, 6'd16, 3'b111, 1'b0, 1'b0, 1'b1),
             mk(3'b000, 6'd30, 6'd12, 3'b111, 1'b0, 1'b1, 1'b0));
        step(1'b0, 6'd0, 6'd0, 3'b000, 1'b1, 1'b0,
             mk(3'b000, 6'd40, 6'd16, 3'b111, 1'b0, 1'b0, 1'b0),
             mk(3'b000, 6'd30, 6'd12, 3'b111, 1'b0, 1'b0, 1'b0));
        // Next oldest is now voice 1.
        step(1'b1, 6'd41, 6'd20, 3'b000, 1'b1, 1'b0,
             mk(3'b010, 6'd41, 6'd20, 3'b111, 1'b0, 1'b0, 1'b1),
             mk(3'b000, 6'd30, 6'd12, 3'b111, 1'b0, 1'b1, 1'b0));

        // Done and new note in the same cycle reuse the finishing voice.
        e = mk(3'b010, 6'd50, 6'd6, 3'b111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd50, 6'd6, 3'b010, 1'b1, 1'b0, e, e);

        // Rest note, then a note while play is low: both ignored.
        e = mk(3'b000, 6'd50, 6'd6, 3'b111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd0, 6'd7, 3'b000, 1'b1, 1'b0, e, e);
        step(1'b1, 6'd33, 6'd3, 3'b000, 1'b0, 1'b0, e, e);

        // Drain one voice, then flush over new_note and done.
        e = mk(3'b000, 6'd50, 6'd6, 3'b110, 1'b0, 1'b0, 1'b0);
        step(1'b0, 6'd0, 6'd0, 3'b001, 1'b1, 1'b0, e, e);
        e = mk(3'b000, 6'd50, 6'd6, 3'b000, 1'b1, 1'b0, 1'b0);
        step(1'b1, 6'd60, 6'd9, 3'b010, 1'b1, 1'b1, e, e);

        e = mk(3'b001, 6'd11, 6'd2, 3'b001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd11, 6'd2, 3'b000, 1'b1, 1'b0, e, e);
        e = mk(3'b010, 6'd12, 6'd5, 3'b011, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd12, 6'd5, 3'b000, 1'b1, 1'b0, e, e);

        // Async reset while the load strobe is showing; clears without a clock edge.
        @(negedge clk);
        sb_check();
        step_no++;
        drive(1'b0, 6'd0, 6'd0, 3'b000, 1'b1, 1'b0);
        #1 reset = 1'b1;
        #1;
        e = mk(3'b000, 6'd0, 6'd0, 3'b000, 1'b1, 1'b0, 1'b0);
        check_a(e);
        check_b(e);
        @(negedge clk);
        reset = 1'b0;

        e = mk(3'b001, 6'd13, 6'd1, 3'b001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6'd13, 6'd1, 3'b000, 1'b1, 1'b0, e, e);
        @(negedge clk);
        sb_check();
        drive(1'b0, 6'd0, 6'd0, 3'b000, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
